// File: rtl/fetch_queue.sv
// fetch_queue: issues sequential fetch PCs to a 1-cycle instruction memory and buffers {pc,instr}
// pairs in a DEPTH-entry FIFO for decode; redirects flush the FIFO and kill the in-flight fetch.
module fetch_queue #(
    parameter int PC_W = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INS_W-1:0]           imem_rdata,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [PC_W-1:0]            id_pc,
    output logic [INS_W-1:0]           id_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PC_W-1:0]  fpc_q, fpc_d, ipc_q, ipc_d;
    logic             inf_q, inf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [PC_W-1:0]  pc_mem_q [DEPTH];
    logic [INS_W-1:0] ins_mem_q [DEPTH];
    logic [CW:0]      used;
    logic             issue, push, pop;

    // An in-flight fetch holds a credit so its return always finds a free slot.
    assign used      = {1'b0, cnt_q} + (CW+1)'(inf_q);
    assign issue     = reset & ~redirect_valid & (used < (CW+1)'(DEPTH));
    assign push      = reset & ~redirect_valid & inf_q;
    assign id_valid  = reset & (cnt_q != '0);
    assign pop       = ~redirect_valid & id_valid & id_ready;
    assign imem_req  = issue;
    assign imem_addr = fpc_q;
    assign id_pc     = id_valid ? pc_mem_q[rd_q] : '0;
    assign id_instr  = id_valid ? ins_mem_q[rd_q] : '0;
    assign count     = reset ? cnt_q : '0;

    always_comb begin
        fpc_d = issue ? fpc_q + PC_W'(4) : fpc_q;
        ipc_d = issue ? fpc_q : ipc_q;
        inf_d = issue;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_q <= RESET_PC;
            ipc_q <= '0;
            inf_q <= 1'b0;
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            fpc_q <= redirect_pc;
            inf_q <= 1'b0;
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
        end else begin
            fpc_q <= fpc_d;
            ipc_q <= ipc_d;
            inf_q <= inf_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            if (push) begin
                pc_mem_q[wr_q]  <= ipc_q;
                ins_mem_q[wr_q] <= imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random stimulus against a queue-based reference model of the fetch front end.
module tb_fetch_queue;
    localparam int PC_W = 9;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            id_valid;
    logic            id_ready = 1'b0;
    logic [PC_W-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [2:0]      count;

    fetch_queue #(.PC_W(PC_W), .INS_W(32), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    always @(posedge clk) imem_rdata <= word(imem_addr);

    // Reference model: FIFO contents as a queue of PCs, fetch PC, one pending fetch.
    int              vectors = 0;
    int              miscompares = 0;
    logic [PC_W-1:0] q[$];
    logic [PC_W-1:0] m_fpc = '0, m_ipc = '0;
    bit              m_inf = 0, known = 0;
    logic [PC_W-1:0] obs_pc, prev_pop = '0, first_pc = '0;
    logic            obs_valid;
    bit              wrap_ok = 0, saw20 = 0, want_first = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit rv, input logic [PC_W-1:0] rpc, input bit rdy);
        bit e_req, e_val;
        @(negedge clk);
        reset = rst; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        #1;
        e_req = rst && !rv && (q.size() + int'(m_inf) < DEPTH);
        e_val = rst && q.size() != 0;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (known) chk("imem_addr", 32'(imem_addr), 32'(m_fpc));
        chk("id_valid", 32'(id_valid), 32'(e_val));
        chk("id_pc", 32'(id_pc), e_val ? 32'(q[0]) : 32'h0);
        chk("id_instr", id_instr, e_val ? word(q[0]) : 32'h0);
        chk("count", 32'(count), rst ? 32'(q.size()) : 32'h0);
        obs_pc = id_pc; obs_valid = id_valid;
        if (id_valid && id_pc == 9'h020) saw20 = 1;
        if (id_valid && rdy && !rv) begin
            if (prev_pop == 9'h1FC && id_pc == 9'h000) wrap_ok = 1;
            if (want_first) begin first_pc = id_pc; want_first = 0; end
            prev_pop = id_pc;
        end
        @(posedge clk);
        if (!rst) begin
            q.delete(); m_fpc = '0; m_inf = 0; known = 1;
        end else if (rv) begin
            q.delete(); m_fpc = rpc; m_inf = 0;
        end else begin
            if (e_val && rdy) void'(q.pop_front());
            if (m_inf) q.push_back(m_ipc);
            m_inf = e_req;
            if (e_req) begin m_ipc = m_fpc; m_fpc = m_fpc + 9'd4; end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, '0, 1);
        for (int i = 0; i < 12; i++) cyc(1, 0, '0, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_noreq", 32'(imem_req), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1, 0, '0, 1);
        cyc(1, 1, 9'h040, 0);
        cyc(1, 0, '0, 1);
        chk("redir_empty", 32'(obs_valid), 32'd0);
        cyc(1, 0, '0, 1);
        cyc(1, 0, '0, 1);
        chk("redir_lat_v", 32'(obs_valid), 32'd1);
        chk("redir_lat_pc", 32'(obs_pc), 32'h040);
        cyc(1, 1, 9'h1F0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, '0, 1);
        chk("wrap", 32'(wrap_ok), 32'd1);
        saw20 = 0;
        cyc(1, 1, 9'h020, 1);
        want_first = 1;
        cyc(1, 1, 9'h080, 1);
        for (int i = 0; i < 8; i++) cyc(1, 0, '0, 1);
        chk("no_020", 32'(saw20), 32'd0);
        chk("first_080", 32'(first_pc), 32'h080);
        cyc(0, 1, 9'h100, 1);
        cyc(1, 0, '0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, '0, 1);
        cyc(1, 1, 9'h033, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, '0, 1);
        for (int i = 0; i < 400; i++) begin
            bit rst, rv, rdy;
            logic [PC_W-1:0] rpc;
            rst = $urandom_range(0, 49) != 0;
            rv  = $urandom_range(0, 9) == 0;
            rdy = $urandom_range(0, 3) != 0;
            rpc = PC_W'($urandom_range(0, 511));
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            cyc(rst, rv, rpc, rdy);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
